// File: rtl/cmos_pkg.sv
// Shared DVP capture types and sizes; the stitch/add stages downstream import these too.
package cmos_pkg;

    localparam int H_ACTIVE_DEF    = 640;
    localparam int PIX_CNT_W       = 12;
    localparam int FRAME_CNT_MIN_W = 4;

    // RGB565 field positions: R[15:11], G[10:5], B[4:0]
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic int frame_cnt_w(input int wait_frames);
        return ($clog2(wait_frames + 1) < FRAME_CNT_MIN_W) ? FRAME_CNT_MIN_W
                                                           : $clog2(wait_frames + 1);
    endfunction

endpackage

// File: rtl/cmos_capture_if.sv
// Raw DVP sensor pins plus the assembled RGB565 stream and status flags.
interface cmos_capture_if;
    import cmos_pkg::*;

    logic       cmos_vsync;
    logic       cmos_href;
    logic [7:0] cmos_data;
    logic       cmos_frame_vsync;
    logic       cmos_frame_href;
    logic       cmos_frame_valid;
    rgb565_t    cmos_frame_data;
    logic       line_err;
    logic       frame_ready;

    modport master (
        input  cmos_vsync, cmos_href, cmos_data,
        output cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data,
        output line_err, frame_ready
    );

    modport slave (
        output cmos_vsync, cmos_href, cmos_data,
        input  cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data,
        input  line_err, frame_ready
    );

endinterface

// File: rtl/cmos_frame_gate.sv
// Counts vsync rising edges after reset and opens the output once WAIT_FRAMES have gone by.
module cmos_frame_gate
    import cmos_pkg::*;
#(
    parameter int WAIT_FRAMES = 10
) (
    input  logic cmos_pclk,
    input  logic sys_rst,
    input  logic vsync,
    output logic ready,
    output logic ready_nxt
);
    localparam int CW = frame_cnt_w(WAIT_FRAMES);
    localparam logic [CW-1:0] WAIT_CNT = CW'(WAIT_FRAMES);

    logic          vsync_d;
    logic          vs_rise;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // ready_nxt lets the output stage open on the same edge the count lands,
    // so the first passed vsync pulse is not clipped.
    always_comb begin
        vs_rise   = vsync & ~vsync_d;
        cnt_nxt   = cnt;
        if (vs_rise && cnt != WAIT_CNT)
            cnt_nxt = cnt + 1'b1;
        ready_nxt = ready | (vs_rise && cnt_nxt == WAIT_CNT);
    end

    always_ff @(posedge cmos_pclk) begin
        if (sys_rst) begin
            vsync_d <= 1'b0;
            cnt     <= '0;
            ready   <= 1'b0;
        end else begin
            vsync_d <= vsync;
            cnt     <= cnt_nxt;
            ready   <= ready_nxt;
        end
    end

endmodule

// File: rtl/cmos_capture.sv
// DVP byte-pair to RGB565 pixel assembler with settle-frame gating and line length check.
module cmos_capture
    import cmos_pkg::*;
#(
    parameter int WAIT_FRAMES = 10,
    parameter int H_ACTIVE    = H_ACTIVE_DEF
) (
    input  logic           cmos_pclk,
    input  logic           sys_rst,
    cmos_capture_if.master bus
);
    localparam logic [PIX_CNT_W-1:0] H_CNT = PIX_CNT_W'(H_ACTIVE);

    logic                 vsync_s1;
    logic                 href_s1;
    logic [7:0]           data_s1;
    logic                 href_d;
    logic                 phase;
    logic [7:0]           byte_hold;
    logic [PIX_CNT_W-1:0] pix_cnt;
    logic                 ready_nxt;
    logic                 href_fall;

    always_ff @(posedge cmos_pclk) begin
        if (sys_rst) begin
            vsync_s1 <= 1'b0;
            href_s1  <= 1'b0;
            data_s1  <= 8'h00;
        end else begin
            vsync_s1 <= bus.cmos_vsync;
            href_s1  <= bus.cmos_href;
            data_s1  <= bus.cmos_data;
        end
    end

    cmos_frame_gate #(.WAIT_FRAMES(WAIT_FRAMES)) u_gate (
        .cmos_pclk (cmos_pclk),
        .sys_rst   (sys_rst),
        .vsync     (vsync_s1),
        .ready     (bus.frame_ready),
        .ready_nxt (ready_nxt)
    );

    assign href_fall = href_d & ~href_s1;

    always_ff @(posedge cmos_pclk) begin
        if (sys_rst) begin
            href_d               <= 1'b0;
            phase                <= 1'b0;
            byte_hold            <= 8'h00;
            pix_cnt              <= '0;
            bus.cmos_frame_data  <= '0;
            bus.cmos_frame_valid <= 1'b0;
            bus.cmos_frame_href  <= 1'b0;
            bus.cmos_frame_vsync <= 1'b0;
            bus.line_err         <= 1'b0;
        end else begin
            href_d <= href_s1;
            phase  <= href_s1 & ~phase;
            if (href_s1 && !phase)
                byte_hold <= data_s1;
            if (href_s1 && phase)
                bus.cmos_frame_data <= {byte_hold, data_s1};
            bus.cmos_frame_valid <= href_s1 & phase & ready_nxt;
            bus.cmos_frame_href  <= href_s1 & ready_nxt;
            bus.cmos_frame_vsync <= vsync_s1 & ready_nxt;
            // phase still high on the fall cycle means an odd byte count
            bus.line_err <= href_fall & ((pix_cnt != H_CNT) | phase);
            if (href_fall)
                pix_cnt <= '0;
            else if (href_s1 && phase && pix_cnt != '1)
                pix_cnt <= pix_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cmos_capture.sv
// Randomized DVP stream against a pixel/line/frame reference model; checks every output every cycle.
module tb_cmos_capture;
    localparam int WAIT_FRAMES = 2;
    localparam int H_ACTIVE    = 640;
    localparam int MAXC        = 65536;

    typedef logic [20:0] obs_t;

    logic clk = 1'b0;
    logic sys_rst;

    cmos_capture_if bus ();

    cmos_capture #(.WAIT_FRAMES(WAIT_FRAMES), .H_ACTIVE(H_ACTIVE)) dut (
        .cmos_pclk (clk),
        .sys_rst   (sys_rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    obs_t  exp_q [MAXC];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    err_seen = 0;
    int    valid_seen = 0;
    int    line_errs, line_vals, frame_vals;
    string tag = "reset";

    // reference model state: byte run length of the current line, vsync rises since reset
    int          run, rises;
    logic        prev_h, prev_v, rdy;
    logic [7:0]  hold;
    logic [15:0] mdata;

    function automatic obs_t obs();
        return {bus.cmos_frame_vsync, bus.cmos_frame_href, bus.cmos_frame_valid,
                bus.line_err, bus.frame_ready, bus.cmos_frame_data};
    endfunction

    // Pins driven in cycle c show up on the outputs two edges later; reset in cycle c zeroes c+1.
    task automatic model(input int c, input logic h0, input logic v0, input logic [7:0] d0,
                         input logic r);
        logic h, v, val, err;
        logic [7:0] d;
        int px;
        h = r ? 1'b0 : h0;
        v = r ? 1'b0 : v0;
        d = r ? 8'h00 : d0;
        if (r) begin
            run = 0; rises = 0; prev_h = 1'b0; prev_v = 1'b0; rdy = 1'b0;
            hold = 8'h00; mdata = 16'h0000;
            exp_q[c+1] = '0;
        end
        px  = (run / 2 > 4095) ? 4095 : run / 2;
        err = prev_h && !h && (px != H_ACTIVE || run % 2 == 1);
        val = 1'b0;
        if (h) begin
            run++;
            if (run % 2 == 0) begin
                mdata = {hold, d};
                val   = 1'b1;
            end else begin
                hold = d;
            end
        end else begin
            run = 0;
        end
        if (v && !prev_v) begin
            if (rises < WAIT_FRAMES) rises++;
            if (rises == WAIT_FRAMES) rdy = 1'b1;
        end
        exp_q[c+2] = {v & rdy, h & rdy, val & rdy, err, rdy, mdata};
        prev_h = h;
        prev_v = v;
    endtask

    task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", t, got, exp);
        end
    endtask

    task automatic step(input logic h, input logic v, input logic [7:0] d, input logic r);
        obs_t got;
        @(posedge clk);
        cyc++;
        #1;
        if (cyc + 3 >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        got = obs();
        total++;
        assert (got === exp_q[cyc]) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp_q[cyc]);
        end
        if (bus.line_err) err_seen++;
        if (bus.cmos_frame_valid) valid_seen++;
        bus.cmos_href  = h;
        bus.cmos_vsync = v;
        bus.cmos_data  = d;
        sys_rst        = r;
        model(cyc, h, v, d, r);
    endtask

    task automatic line(input int nbytes, input bit f81f, input int vs_at);
        int e0, v0;
        logic [7:0] d;
        logic v;
        e0 = err_seen;
        v0 = valid_seen;
        for (int i = 0; i < nbytes; i++) begin
            d = 8'($urandom);
            if (f81f && i == 0) d = 8'hF8;
            if (f81f && i == 1) d = 8'h1F;
            v = (vs_at >= 0 && i >= vs_at && i < vs_at + 4);
            step(1'b1, v, d, 1'b0);
            if (f81f && i == 3)
                chk("f81f_pixel", {bus.cmos_frame_valid, bus.cmos_frame_data}, {1'b1, 16'hF81F});
        end
        repeat (8) step(1'b0, 1'b0, 8'h00, 1'b0);
        line_errs = err_seen - e0;
        line_vals = valid_seen - v0;
    endtask

    // Lines first, then the vsync pulse that closes the frame.
    task automatic frame(input int nlines, input bit f81f);
        int v0;
        v0 = valid_seen;
        for (int l = 0; l < nlines; l++) line(1280, f81f && l == 0, -1);
        repeat (3) step(1'b0, 1'b1, 8'h00, 1'b0);
        repeat (5) step(1'b0, 1'b0, 8'h00, 1'b0);
        frame_vals = valid_seen - v0;
    endtask

    initial begin
        sys_rst        = 1'b1;
        bus.cmos_href  = 1'b0;
        bus.cmos_vsync = 1'b0;
        bus.cmos_data  = 8'h00;
        model(0, 1'b0, 1'b0, 8'h00, 1'b1);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("reset_outputs", obs(), 32'h0);
        repeat (5) step(1'b0, 1'b0, 8'h00, 1'b0);

        tag = "discard";
        frame(4, 1'b0);
        chk("f1_valid", frame_vals, 0);
        chk("f1_ready", bus.frame_ready, 0);
        frame(4, 1'b0);
        chk("f2_valid", frame_vals, 0);
        chk("f2_ready", bus.frame_ready, 1);

        tag = "pass";
        frame(4, 1'b1);
        chk("f3_valid", frame_vals, 2560);

        tag = "len1279";
        line(1279, 1'b0, -1);
        chk("err_1279", line_errs, 1);
        chk("val_1279", line_vals, 639);
        tag = "len1280";
        line(1280, 1'b0, -1);
        chk("err_1280", line_errs, 0);
        chk("val_1280", line_vals, 640);
        tag = "px638";
        line(1276, 1'b0, -1);
        chk("err_638", line_errs, 1);
        chk("val_638", line_vals, 638);
        tag = "vs_in_line";
        line(1280, 1'b0, 300);
        chk("err_vs_in_line", line_errs, 0);
        tag = "px4096";
        line(8192, 1'b0, -1);
        chk("err_4096", line_errs, 1);
        chk("val_4096", line_vals, 4096);
        tag = "px4736";
        line(9472, 1'b0, -1);
        chk("err_4736_nowrap", line_errs, 1);

        tag = "midrst";
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        step(1'b1, 1'b0, 8'($urandom), 1'b1);
        step(1'b1, 1'b0, 8'($urandom), 1'b0);
        chk("midrst_outputs", obs(), 32'h0);
        for (int i = 0; i < 978; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        repeat (8) step(1'b0, 1'b0, 8'h00, 1'b0);
        frame(2, 1'b0);
        chk("rst_fa_valid", frame_vals, 0);
        chk("rst_fa_ready", bus.frame_ready, 0);
        frame(2, 1'b0);
        chk("rst_fb_valid", frame_vals, 0);
        chk("rst_fb_ready", bus.frame_ready, 1);
        tag = "rst_pass";
        frame(2, 1'b0);
        chk("rst_fc_valid", frame_vals, 1280);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmos_capture.md
CMOS_CAPTURE -- requirements
Module: cmos_capture

Interface
REQ-001 Parameter WAIT_FRAMES, default 10: number of complete frames discarded after reset while the sensor settles.
REQ-002 Parameter H_ACTIVE, default 640: expected RGB565 pixels per line.
REQ-003 cmos_pclk  input  1  sensor pixel clock; the only clock; all logic on its rising edge.
REQ-004 sys_rst  input  1  reset, synchronous, active-high.
REQ-005 cmos_vsync  input  1  raw sensor frame sync, active-high.
REQ-006 cmos_href  input  1  raw sensor line valid, active-high.
REQ-007 cmos_data  input  8  raw DVP byte: high byte first, then low byte.
REQ-008 cmos_frame_vsync  output  1  vsync aligned to the output stream and gated.
REQ-009 cmos_frame_href  output  1  href aligned to the output stream and gated.
REQ-010 cmos_frame_valid  output  1  one-cycle strobe per assembled pixel.
REQ-011 cmos_frame_data  output  16  RGB565 pixel, {first byte, second byte}.
REQ-012 line_err  output  1  one-cycle pulse when a finished line has a bad length.
REQ-013 frame_ready  output  1  level; high once WAIT_FRAMES frames have been discarded.

Function
REQ-014 All three raw inputs SHALL be registered once (stage S1) before any use.
REQ-015 Byte phase: a 1-bit flag SHALL clear while S1 href=0 and SHALL toggle each cycle while S1 href=1.
REQ-016 Phase=0: the byte SHALL be held; phase=1: cmos_frame_data <= {held byte, current byte} and cmos_frame_valid <= 1 on the next edge. The output is 2 cycles after the second byte at the pins.
REQ-017 cmos_frame_valid SHALL be 0 on every cycle not covered by REQ-016; cmos_frame_data SHALL hold its last value.
REQ-018 cmos_frame_href and cmos_frame_vsync SHALL be S1 href/vsync delayed one further register, so that valid always falls inside href.
REQ-019 Frame counter (4 bits minimum; sized by WAIT_FRAMES) SHALL increment on each S1 vsync rising edge and SHALL saturate at WAIT_FRAMES.
REQ-020 frame_ready SHALL assert only at the vsync rising edge at which the counter reaches WAIT_FRAMES, so that no partial frame passes.
REQ-021 While frame_ready=0, cmos_frame_href, cmos_frame_vsync and cmos_frame_valid SHALL be forced 0.
REQ-022 Pixel counter (12 bits) SHALL count assembled pixels per line, saturate at 4095, and clear on the cycle after the href falling edge.
REQ-023 On the S1 href falling edge, line_err SHALL pulse for 1 cycle if the pixel count != H_ACTIVE or phase=1 (odd byte count).
REQ-024 line_err SHALL be reported regardless of frame_ready.
REQ-025 href held high across a vsync edge is legal: counters SHALL continue counting and no extra error SHALL be raised.

Reset
REQ-026 On sys_rst=1 at a clock edge, all registers SHALL clear. Outputs read 0: data=16'h0000, valid, href, vsync, line_err, frame_ready=0.
REQ-027 Reset asserted mid-line or mid-frame SHALL abandon that line or frame.
REQ-028 After reset releases, the discard of WAIT_FRAMES frames SHALL restart from zero.

Structure
REQ-029 H_ACTIVE default, the counter widths and RGB565 field positions (R[15:11], G[10:5], B[4:0]) SHALL live in shared package cmos_pkg; downstream stitch/add stages reuse them.
REQ-030 The block SHALL be flat; the frame-settle counter MAY be sub-module cmos_frame_gate (inputs vsync, WAIT_FRAMES; output ready).
REQ-031 Outputs SHALL be registered with no combinational path from the inputs.

Verification
REQ-032 WAIT_FRAMES=2, 3 frames of 4 lines x 640 px: only frame 3 appears on the outputs; frame_ready rises at the 2nd vsync rising edge.
REQ-033 Bytes 8'hF8, 8'h1F on consecutive href cycles -> cmos_frame_data=16'hF81F with valid=1, 2 cycles after 8'h1F.
REQ-034 Line of 1279 bytes -> line_err=1 for exactly 1 cycle after the href fall. Line of 1280 bytes -> line_err=0.
REQ-035 Line of 638 px with H_ACTIVE=640 -> line_err pulse; the 638 valid strobes are still emitted.
REQ-036 sys_rst pulsed mid-line in frame 3 -> next cycle all outputs 0, frame_ready=0, and 2 further frames are discarded.
REQ-037 4096 px line -> counter saturates at 4095 with no wrap, and line_err pulses.
